// File: rtl/regfile_pkg.sv
// Shared types and default widths for the multi-port register file.
package regfile_pkg;

    typedef enum logic {RF_INIT, RF_RUN} rf_state_t;

    localparam int RF_DATA_WIDTH = 32;
    localparam int RF_ADDR_WIDTH = 5;

endpackage

// File: rtl/regfile_init_ctrl.sv
// Post-reset sweep controller: walks every entry once writing zero, then
// hands the array over to the functional ports and raises ready.
module regfile_init_ctrl
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  ready,
    output logic                  init_we,
    output logic [ADDR_WIDTH-1:0] init_addr
);

    rf_state_t             state;
    rf_state_t             state_nxt;
    logic [ADDR_WIDTH-1:0] init_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RF_INIT;
            init_ptr <= '0;
        end else begin
            state <= state_nxt;
            if (state == RF_INIT) begin
                init_ptr <= init_ptr + 1'b1;
            end
        end
    end

    // Leave INIT on the edge that clears the last entry, so ready follows one cycle later.
    always_comb begin
        state_nxt = state;
        init_we   = 1'b0;
        ready     = 1'b0;
        case (state)
            RF_INIT: begin
                init_we = 1'b1;
                if (init_ptr == '1) begin
                    state_nxt = RF_RUN;
                end
            end
            RF_RUN: begin
                ready = 1'b1;
            end
            default: begin
                state_nxt = RF_INIT;
            end
        endcase
    end

    assign init_addr = init_ptr;

endmodule

// File: rtl/regfile_multiport.sv
// Register file with NUM_READ registered read ports and one write port,
// optional hardwired-zero entry 0 and optional write-to-read forwarding.
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int NUM_READ   = 2,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    output logic                           ready,
    input  logic [NUM_READ-1:0]            rd_en,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_READ*DATA_WIDTH-1:0] rd_data,
    input  logic                           wr_en,
    input  logic [ADDR_WIDTH-1:0]          wr_addr,
    input  logic [DATA_WIDTH-1:0]          wr_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  init_we;
    logic [ADDR_WIDTH-1:0] init_addr;
    logic                  usr_we;
    logic                  arr_we;
    logic [ADDR_WIDTH-1:0] arr_addr;
    logic [DATA_WIDTH-1:0] arr_data;

    regfile_init_ctrl #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_init_ctrl (
        .clk       (clk),
        .rst       (rst),
        .ready     (ready),
        .init_we   (init_we),
        .init_addr (init_addr)
    );

    // A functional write only counts once live; writes to a hardwired zero are dropped here
    // so the bypass compare below never sees them either.
    assign usr_we = ready && wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

    always_comb begin
        arr_we   = init_we | usr_we;
        arr_addr = wr_addr;
        arr_data = wr_data;
        if (init_we) begin
            arr_addr = init_addr;
            arr_data = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (arr_we) begin
            mem[arr_addr] <= arr_data;
        end
    end

    for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
        logic [ADDR_WIDTH-1:0] addr_p0;
        logic [DATA_WIDTH-1:0] sel_p0;
        logic [DATA_WIDTH-1:0] data_p1;

        assign addr_p0 = rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];

        // p0: select array value, forwarded write data or hardwired zero
        always_comb begin
            sel_p0 = mem[addr_p0];
            if ((ZERO_REG != 0) && (addr_p0 == '0)) begin
                sel_p0 = '0;
            end else if ((BYPASS != 0) && usr_we && (wr_addr == addr_p0)) begin
                sel_p0 = wr_data;
            end
        end

        // p1: registered read port output
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                data_p1 <= '0;
            end else if (!ready) begin
                data_p1 <= '0;
            end else if (rd_en[p]) begin
                data_p1 <= sel_p0;
            end
        end

        assign rd_data[p*DATA_WIDTH +: DATA_WIDTH] = data_p1;
    end

endmodule
